// File: rtl/ssd1306_spi_decoder_pkg.sv
// Shared constants for the SSD1306 SPI decoder: opcodes, addressing modes,
// command-FSM states and framebuffer geometry.
package ssd1306_pkg;

  localparam int FB_COLS   = 128;
  localparam int FB_PAGES  = 8;
  localparam int FB_ADDR_W = 10;
  localparam int COL_W     = 7;
  localparam int PAGE_W    = 3;

  localparam logic [7:0] CMD_MEM_MODE    = 8'h20;
  localparam logic [7:0] CMD_COL_ADDR    = 8'h21;
  localparam logic [7:0] CMD_PAGE_ADDR   = 8'h22;
  localparam logic [7:0] CMD_CONTRAST    = 8'h81;
  localparam logic [7:0] CMD_CHARGE_PUMP = 8'h8D;
  localparam logic [7:0] CMD_MUX_RATIO   = 8'hA8;
  localparam logic [7:0] CMD_DISP_OFFSET = 8'hD3;
  localparam logic [7:0] CMD_CLK_DIV     = 8'hD5;
  localparam logic [7:0] CMD_PRECHARGE   = 8'hD9;
  localparam logic [7:0] CMD_COM_PINS    = 8'hDA;
  localparam logic [7:0] CMD_VCOMH       = 8'hDB;
  localparam logic [7:0] CMD_DISP_OFF    = 8'hAE;
  localparam logic [7:0] CMD_DISP_ON     = 8'hAF;
  localparam logic [7:0] CMD_NORMAL      = 8'hA6;
  localparam logic [7:0] CMD_INVERT      = 8'hA7;

  typedef enum logic [1:0] {
    MODE_HORIZ = 2'd0,
    MODE_VERT  = 2'd1,
    MODE_PAGE  = 2'd2,
    MODE_RSVD  = 2'd3
  } addr_mode_e;

  // Which multi-byte command the FSM is currently collecting arguments for.
  typedef enum logic [1:0] {
    ARG_COL      = 2'd0,
    ARG_PAGE     = 2'd1,
    ARG_MODE     = 2'd2,
    ARG_CONTRAST = 2'd3
  } arg_kind_e;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARG1  = 2'd1;
  localparam logic [1:0] ST_ARG2  = 2'd2;
  localparam logic [1:0] ST_SKIP1 = 2'd3;

  // Commands that carry one argument byte we have no use for.
  function automatic logic is_skip_cmd(input logic [7:0] op);
    case (op)
      CMD_CHARGE_PUMP, CMD_MUX_RATIO, CMD_DISP_OFFSET, CMD_CLK_DIV,
      CMD_PRECHARGE, CMD_COM_PINS, CMD_VCOMH: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ssd1306_spi_decoder_if.sv
// Bundle of the raw SPI pins and the framebuffer/status outputs of the decoder.
interface ssd1306_spi_decoder_if;
  import ssd1306_pkg::*;

  logic                 spi_sclk;
  logic                 spi_mosi;
  logic                 spi_cs_n;
  logic                 spi_dc;
  logic                 fb_we;
  logic [FB_ADDR_W-1:0] fb_addr;
  logic [7:0]           fb_wdata;
  logic                 display_on;
  logic                 invert;
  logic [7:0]           contrast;
  logic                 frame_done;

  modport master (
    output spi_sclk, spi_mosi, spi_cs_n, spi_dc,
    input  fb_we, fb_addr, fb_wdata, display_on, invert, contrast, frame_done
  );

  modport slave (
    input  spi_sclk, spi_mosi, spi_cs_n, spi_dc,
    output fb_we, fb_addr, fb_wdata, display_on, invert, contrast, frame_done
  );

endinterface

// File: rtl/ssd1306_spi_decoder_spi_byte_rx.sv
// SPI mode-0 byte receiver: synchronizes the raw pins, detects SCLK rises and
// assembles MSB-first bytes tagged with the D/C level of their last bit.
module spi_byte_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sclk_i,
  input  logic       mosi_i,
  input  logic       cs_n_i,
  input  logic       dc_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       byte_dc_o
);

  localparam int LANES = 4;
  // Lane order {sclk, cs_n, mosi, dc}; cs_n idles deasserted out of reset.
  localparam logic [LANES-1:0] LANE_RST = 4'b0100;

  logic [LANES-1:0] raw;
  logic [LANES-1:0] synced;

  assign raw = {sclk_i, cs_n_i, mosi_i, dc_i};

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain_q;
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) chain_q <= {SYNC_STAGES{LANE_RST[gi]}};
        else        chain_q <= {chain_q[SYNC_STAGES-2:0], raw[gi]};
      end
      assign synced[gi] = chain_q[SYNC_STAGES-1];
    end
  endgenerate

  logic       sclk_prev_q;
  logic       rise_q;
  logic       cs_n_q;
  logic       mosi_q;
  logic       dc_q;
  logic [2:0] bit_cnt_q;
  logic [6:0] shift_q;
  logic       byte_valid_q;
  logic [7:0] byte_q;
  logic       byte_dc_q;

  // Registered edge detect; the data lanes get the same extra stage so they
  // stay aligned with the rise they belong to.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sclk_prev_q <= 1'b0;
      rise_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      dc_q        <= 1'b0;
    end else begin
      sclk_prev_q <= synced[3];
      rise_q      <= synced[3] & ~sclk_prev_q;
      cs_n_q      <= synced[2];
      mosi_q      <= synced[1];
      dc_q        <= synced[0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bit_cnt_q    <= 3'd0;
      shift_q      <= 7'd0;
      byte_valid_q <= 1'b0;
      byte_q       <= 8'd0;
      byte_dc_q    <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      if (cs_n_q) begin
        bit_cnt_q <= 3'd0;
      end else if (rise_q) begin
        shift_q   <= {shift_q[5:0], mosi_q};
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_valid_q <= 1'b1;
          byte_q       <= {shift_q, mosi_q};
          byte_dc_q    <= dc_q;
        end
      end
    end
  end

  assign byte_valid_o = byte_valid_q;
  assign byte_o       = byte_q;
  assign byte_dc_o    = byte_dc_q;

endmodule

// File: rtl/ssd1306_spi_decoder.sv
// SSD1306 SPI stream decoder: command subset interpreter plus addressed
// framebuffer write generation with window/addressing-mode pointer handling.
module ssd1306_spi_decoder
  import ssd1306_pkg::*;
#(
  parameter int         SYNC_STAGES  = 2,
  parameter logic [7:0] CONTRAST_RST = 8'h7F
) (
  input logic            clock,
  input logic            reset,
  ssd1306_spi_decoder_if.slave bus
);

  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_dc;

  spi_byte_rx #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rx (
    .clock        (clock),
    .reset        (reset),
    .sclk_i       (bus.spi_sclk),
    .mosi_i       (bus.spi_mosi),
    .cs_n_i       (bus.spi_cs_n),
    .dc_i         (bus.spi_dc),
    .byte_valid_o (rx_valid),
    .byte_o       (rx_byte),
    .byte_dc_o    (rx_dc)
  );

  logic [1:0]           state_q, state_d;
  arg_kind_e            arg_kind_q, arg_kind_d;
  addr_mode_e           mode_q, mode_d;
  logic [COL_W-1:0]     col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
  logic [PAGE_W-1:0]    page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;
  logic                 fb_we_q, fb_we_d;
  logic [FB_ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [7:0]           fb_wdata_q, fb_wdata_d;
  logic                 display_on_q, display_on_d;
  logic                 invert_q, invert_d;
  logic [7:0]           contrast_q, contrast_d;
  logic                 frame_done_q, frame_done_d;

  // Window stepping: equality with the end bound wraps to the start bound,
  // otherwise the natural width overflow gives 127->0 / 7->0 for start > end.
  logic              col_wrap, page_wrap;
  logic [COL_W-1:0]  col_next;
  logic [PAGE_W-1:0] page_next;

  assign col_wrap  = (col_q == col_end_q);
  assign page_wrap = (page_q == page_end_q);
  assign col_next  = col_wrap ? col_start_q : col_q + 7'd1;
  assign page_next = page_wrap ? page_start_q : page_q + 3'd1;

  always_comb begin
    state_d      = state_q;
    arg_kind_d   = arg_kind_q;
    mode_d       = mode_q;
    col_d        = col_q;
    page_d       = page_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    page_start_d = page_start_q;
    page_end_d   = page_end_q;
    fb_we_d      = 1'b0;
    fb_addr_d    = fb_addr_q;
    fb_wdata_d   = fb_wdata_q;
    display_on_d = display_on_q;
    invert_d     = invert_q;
    contrast_d   = contrast_q;
    frame_done_d = 1'b0;

    if (rx_valid && rx_dc) begin
      fb_we_d    = 1'b1;
      fb_addr_d  = {page_q, col_q};
      fb_wdata_d = rx_byte;
      case (mode_q)
        MODE_HORIZ: begin
          col_d = col_next;
          if (col_wrap) begin
            page_d       = page_next;
            frame_done_d = page_wrap;
          end
        end
        MODE_VERT: begin
          page_d = page_next;
          if (page_wrap) begin
            col_d        = col_next;
            frame_done_d = col_wrap;
          end
        end
        default: col_d = col_next;
      endcase
    end else if (rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_byte == CMD_COL_ADDR) begin
            state_d    = ST_ARG1;
            arg_kind_d = ARG_COL;
          end else if (rx_byte == CMD_PAGE_ADDR) begin
            state_d    = ST_ARG1;
            arg_kind_d = ARG_PAGE;
          end else if (rx_byte == CMD_MEM_MODE) begin
            state_d    = ST_ARG1;
            arg_kind_d = ARG_MODE;
          end else if (rx_byte == CMD_CONTRAST) begin
            state_d    = ST_ARG1;
            arg_kind_d = ARG_CONTRAST;
          end else if (is_skip_cmd(rx_byte)) begin
            state_d = ST_SKIP1;
          end else if (rx_byte[7:3] == 5'b10110) begin
            page_d = rx_byte[2:0];
          end else if (rx_byte[7:4] == 4'h0) begin
            col_d[3:0] = rx_byte[3:0];
          end else if (rx_byte[7:3] == 5'b00010) begin
            col_d[6:4] = rx_byte[2:0];
          end else if (rx_byte == CMD_DISP_ON) begin
            display_on_d = 1'b1;
          end else if (rx_byte == CMD_DISP_OFF) begin
            display_on_d = 1'b0;
          end else if (rx_byte == CMD_INVERT) begin
            invert_d = 1'b1;
          end else if (rx_byte == CMD_NORMAL) begin
            invert_d = 1'b0;
          end
        end
        ST_ARG1: begin
          case (arg_kind_q)
            ARG_COL: begin
              col_start_d = rx_byte[6:0];
              col_d       = rx_byte[6:0];
              state_d     = ST_ARG2;
            end
            ARG_PAGE: begin
              page_start_d = rx_byte[2:0];
              page_d       = rx_byte[2:0];
              state_d      = ST_ARG2;
            end
            ARG_MODE: begin
              // Mode 3 is reserved on the controller; keep the current mode.
              if (rx_byte[1:0] != 2'd3) mode_d = addr_mode_e'(rx_byte[1:0]);
              state_d = ST_IDLE;
            end
            ARG_CONTRAST: begin
              contrast_d = rx_byte;
              state_d    = ST_IDLE;
            end
          endcase
        end
        ST_ARG2: begin
          if (arg_kind_q == ARG_COL) col_end_d = rx_byte[6:0];
          else                       page_end_d = rx_byte[2:0];
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      arg_kind_q   <= ARG_COL;
      mode_q       <= MODE_PAGE;
      col_q        <= '0;
      page_q       <= '0;
      col_start_q  <= '0;
      col_end_q    <= 7'(FB_COLS - 1);
      page_start_q <= '0;
      page_end_q   <= 3'(FB_PAGES - 1);
      fb_we_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_wdata_q   <= 8'd0;
      display_on_q <= 1'b0;
      invert_q     <= 1'b0;
      contrast_q   <= CONTRAST_RST;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      arg_kind_q   <= arg_kind_d;
      mode_q       <= mode_d;
      col_q        <= col_d;
      page_q       <= page_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      page_start_q <= page_start_d;
      page_end_q   <= page_end_d;
      fb_we_q      <= fb_we_d;
      fb_addr_q    <= fb_addr_d;
      fb_wdata_q   <= fb_wdata_d;
      display_on_q <= display_on_d;
      invert_q     <= invert_d;
      contrast_q   <= contrast_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.fb_we      = fb_we_q;
  assign bus.fb_addr    = fb_addr_q;
  assign bus.fb_wdata   = fb_wdata_q;
  assign bus.display_on = display_on_q;
  assign bus.invert     = invert_q;
  assign bus.contrast   = contrast_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_ssd1306_spi_decoder.sv
// Self-checking bench for ssd1306_spi_decoder: directed vector tables, corner
// sequences and a randomized command/data stream against a reference model.
module tb_ssd1306_spi_decoder;

  localparam int SYNC = 2;

  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  ssd1306_spi_decoder_if bus();

  ssd1306_spi_decoder #(
    .SYNC_STAGES  (SYNC),
    .CONTRAST_RST (8'h7F)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int n_tests;
  int n_fail;
  int stray_fd;

  typedef struct {
    int addr;
    int data;
    bit fd;
  } strobe_t;

  strobe_t got_q[$];
  strobe_t exp_q[$];

  typedef struct {
    bit         dc;
    logic [7:0] val;
    int         n;
    int         addr;
    int         data;
    bit         fd;
  } vec_t;

  vec_t vecs[$];

  always @(posedge clk) begin
    #1;
    if (bus.fb_we === 1'b1)
      got_q.push_back('{addr: int'(bus.fb_addr), data: int'(bus.fb_wdata), fd: bus.frame_done});
    else if (bus.frame_done === 1'b1)
      stray_fd++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic spi_bit(input logic b, input logic dc);
    @(negedge clk);
    bus.spi_sclk = 1'b0;
    bus.spi_mosi = b;
    bus.spi_dc   = dc;
    @(negedge clk);
    @(negedge clk);
    bus.spi_sclk = 1'b1;
    @(negedge clk);
  endtask

  task automatic spi_byte(input logic dc, input logic [7:0] val);
    for (int i = 7; i >= 0; i--) spi_bit(val[i], dc);
  endtask

  task automatic settle();
    @(negedge clk);
    bus.spi_sclk = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    bus.spi_sclk = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;
    bus.spi_dc   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    bus.spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " fb_we"},      int'(bus.fb_we), 0);
    check({tag, " fb_addr"},    int'(bus.fb_addr), 0);
    check({tag, " fb_wdata"},   int'(bus.fb_wdata), 0);
    check({tag, " display_on"}, int'(bus.display_on), 0);
    check({tag, " invert"},     int'(bus.invert), 0);
    check({tag, " contrast"},   int'(bus.contrast), 8'h7F);
    check({tag, " frame_done"}, int'(bus.frame_done), 0);
  endtask

  function automatic void add_vec(bit dc, logic [7:0] val, int n, int addr, int data, bit fd);
    vecs.push_back('{dc: dc, val: val, n: n, addr: addr, data: data, fd: fd});
  endfunction

  function automatic void add_cmd(logic [7:0] val);
    add_vec(1'b0, val, 0, 0, 0, 1'b0);
  endfunction

  task automatic run_vectors(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      got_q.delete();
      spi_byte(vecs[i].dc, vecs[i].val);
      settle();
      check($sformatf("%s[%0d] strobes", tag, i), got_q.size(), vecs[i].n);
      if (vecs[i].n == 1 && got_q.size() == 1) begin
        check($sformatf("%s[%0d] addr", tag, i), got_q[0].addr, vecs[i].addr);
        check($sformatf("%s[%0d] data", tag, i), got_q[0].data, vecs[i].data);
        check($sformatf("%s[%0d] frame_done", tag, i), int'(got_q[0].fd), int'(vecs[i].fd));
      end
    end
    vecs.delete();
  endtask

  // Reference model: display state kept as plain integers, commands parsed by
  // counting outstanding argument bytes.
  int m_mode, m_col, m_page, m_cs, m_ce, m_ps, m_pe;
  int m_contrast, m_on, m_inv, m_pend, m_op;

  function automatic void model_reset();
    m_mode = 2; m_col = 0; m_page = 0;
    m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 7;
    m_contrast = 8'h7F; m_on = 0; m_inv = 0; m_pend = 0; m_op = 0;
  endfunction

  function automatic int step(int cur, int s, int e, int n);
    return (cur == e) ? s : (cur + 1) % n;
  endfunction

  function automatic void model_byte(bit dc, int b);
    bit fd;
    bit cw, pw;
    if (dc) begin
      fd = 1'b0;
      cw = (m_col == m_ce);
      pw = (m_page == m_pe);
      exp_q.push_back('{addr: m_page * 128 + m_col, data: b, fd: 1'b0});
      if (m_mode == 0) begin
        m_col = step(m_col, m_cs, m_ce, 128);
        if (cw) begin m_page = step(m_page, m_ps, m_pe, 8); fd = pw; end
      end else if (m_mode == 1) begin
        m_page = step(m_page, m_ps, m_pe, 8);
        if (pw) begin m_col = step(m_col, m_cs, m_ce, 128); fd = cw; end
      end else begin
        m_col = step(m_col, m_cs, m_ce, 128);
      end
      exp_q[exp_q.size() - 1].fd = fd;
    end else if (m_pend > 0) begin
      if (m_op == 'h21) begin
        if (m_pend == 2) begin m_cs = b % 128; m_col = m_cs; end
        else m_ce = b % 128;
      end else if (m_op == 'h22) begin
        if (m_pend == 2) begin m_ps = b % 8; m_page = m_ps; end
        else m_pe = b % 8;
      end else if (m_op == 'h20) begin
        if (b % 4 != 3) m_mode = b % 4;
      end else if (m_op == 'h81) begin
        m_contrast = b;
      end
      m_pend--;
    end else begin
      m_op = b;
      if (b == 'h21 || b == 'h22) m_pend = 2;
      else if (b == 'h20 || b == 'h81 || b == 'h8D || b == 'hA8 || b == 'hD3 ||
               b == 'hD5 || b == 'hD9 || b == 'hDA || b == 'hDB) m_pend = 1;
      else if (b >= 'hB0 && b <= 'hB7) m_page = b - 'hB0;
      else if (b <= 'h0F) m_col = (m_col / 16) * 16 + b;
      else if (b >= 'h10 && b <= 'h17) m_col = (m_col % 16) + (b - 'h10) * 16;
      else if (b == 'hAF) m_on = 1;
      else if (b == 'hAE) m_on = 0;
      else if (b == 'hA7) m_inv = 1;
      else if (b == 'hA6) m_inv = 0;
    end
  endfunction

  task automatic send_model(input bit dc, input int b);
    spi_byte(dc, 8'(b));
    model_byte(dc, b);
  endtask

  initial begin
    int bad, fdc, r, lim;
    logic [7:0] pat;
    n_tests  = 0;
    n_fail   = 0;
    stray_fd = 0;
    rst_n        = 1'b0;
    bus.spi_sclk = 1'b0;
    bus.spi_mosi = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_dc   = 1'b0;

    do_reset();
    check_reset_outputs("reset");

    // Full frame in horizontal mode.
    got_q.delete();
    spi_byte(1'b0, 8'h20);
    spi_byte(1'b0, 8'h00);
    for (int i = 0; i < 1024; i++) spi_byte(1'b1, 8'(i));
    settle();
    check("horiz strobe count", got_q.size(), 1024);
    bad = 0;
    fdc = 0;
    for (int i = 0; i < got_q.size() && i < 1024; i++) begin
      if (got_q[i].addr != i || got_q[i].data != (i % 256) || got_q[i].fd != (i == 1023)) bad++;
      if (got_q[i].fd) fdc++;
    end
    check("horiz sequence mismatches", bad, 0);
    check("horiz frame_done count", fdc, 1);

    // Column/page window in horizontal mode.
    add_cmd(8'h21); add_cmd(8'h10); add_cmd(8'h13);
    add_cmd(8'h22); add_cmd(8'h02); add_cmd(8'h03);
    add_vec(1, 8'hC0, 1, 272, 8'hC0, 0);
    add_vec(1, 8'hC1, 1, 273, 8'hC1, 0);
    add_vec(1, 8'hC2, 1, 274, 8'hC2, 0);
    add_vec(1, 8'hC3, 1, 275, 8'hC3, 0);
    add_vec(1, 8'hC4, 1, 400, 8'hC4, 0);
    add_vec(1, 8'hC5, 1, 401, 8'hC5, 0);
    add_vec(1, 8'hC6, 1, 402, 8'hC6, 0);
    add_vec(1, 8'hC7, 1, 403, 8'hC7, 1);
    add_vec(1, 8'hC8, 1, 272, 8'hC8, 0);
    run_vectors("window");

    // Page mode with page / nibble column commands.
    do_reset();
    add_cmd(8'hB5); add_cmd(8'h03); add_cmd(8'h12);
    add_vec(1, 8'h11, 1, 675, 8'h11, 0);
    add_vec(1, 8'h22, 1, 676, 8'h22, 0);
    run_vectors("pagemode");

    // Partial byte aborted by CS_n, then a full byte with latency check.
    got_q.delete();
    for (int i = 0; i < 5; i++) spi_bit(1'b1, 1'b1);
    @(negedge clk);
    bus.spi_sclk = 1'b0;
    bus.spi_cs_n = 1'b1;
    repeat (6) @(negedge clk);
    bus.spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    pat = 8'hA5;
    for (int i = 7; i >= 1; i--) spi_bit(pat[i], 1'b1);
    @(negedge clk);
    bus.spi_sclk = 1'b0;
    bus.spi_mosi = pat[0];
    @(negedge clk);
    @(negedge clk);
    bus.spi_sclk = 1'b1;
    @(posedge clk);
    repeat (SYNC + 1) @(posedge clk);
    #1;
    check("latency before strobe", int'(bus.fb_we), 0);
    @(posedge clk);
    #1;
    check("latency strobe", int'(bus.fb_we), 1);
    check("partial data", int'(bus.fb_wdata), 8'hA5);
    check("partial addr", int'(bus.fb_addr), 677);
    settle();
    check("partial strobe count", got_q.size(), 1);

    // Display state commands; skipped argument must not act as a column command.
    do_reset();
    add_cmd(8'h81); add_cmd(8'h40); add_cmd(8'hAF); add_cmd(8'hA7);
    add_cmd(8'h8D); add_cmd(8'h14);
    add_vec(1, 8'h77, 1, 0, 8'h77, 0);
    add_vec(1, 8'h3C, 1, 1, 8'h3C, 0);
    run_vectors("state");
    check("contrast", int'(bus.contrast), 8'h40);
    check("display_on", int'(bus.display_on), 1);
    check("invert", int'(bus.invert), 1);

    // Asynchronous reset in the middle of a column-address command.
    spi_byte(1'b0, 8'h21);
    spi_byte(1'b0, 8'h05);
    for (int i = 0; i < 3; i++) spi_bit(1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async reset");
    bus.spi_sclk = 1'b0;
    bus.spi_cs_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    bus.spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    check_reset_outputs("after reset");
    add_vec(1, 8'h99, 1, 0, 8'h99, 0);
    run_vectors("post-reset");

    // Randomized command/data stream against the reference model.
    do_reset();
    model_reset();
    got_q.delete();
    exp_q.delete();
    for (int n = 0; n < 220; n++) begin
      r = $urandom_range(0, 99);
      if (r < 50) begin
        send_model(1, $urandom_range(0, 255));
      end else if (r < 60) begin
        send_model(0, 'h21);
        send_model(0, $urandom_range(0, 255));
        if ($urandom_range(0, 3) == 0) send_model(1, $urandom_range(0, 255));
        send_model(0, $urandom_range(0, 255));
      end else if (r < 68) begin
        send_model(0, 'h22);
        send_model(0, $urandom_range(0, 255));
        send_model(0, $urandom_range(0, 255));
      end else if (r < 74) begin
        send_model(0, 'h20);
        send_model(0, $urandom_range(0, 3));
      end else if (r < 78) begin
        send_model(0, 'h81);
        send_model(0, $urandom_range(0, 255));
      end else if (r < 82) begin
        send_model(0, 'hB0 + $urandom_range(0, 7));
      end else if (r < 86) begin
        send_model(0, $urandom_range(0, 23));
      end else if (r < 90) begin
        send_model(0, 'hA6 + $urandom_range(0, 1) + 8 * $urandom_range(0, 1));
      end else if (r < 94) begin
        lim = $urandom_range(1, 7);
        for (int k = 0; k < lim; k++) spi_bit(1'($urandom_range(0, 1)), 1'b1);
        @(negedge clk);
        bus.spi_sclk = 1'b0;
        bus.spi_cs_n = 1'b1;
        repeat (5) @(negedge clk);
        bus.spi_cs_n = 1'b0;
        repeat (3) @(negedge clk);
      end else begin
        send_model(0, $urandom_range(0, 255));
      end
    end
    settle();
    check("random strobe count", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("random strobe %0d {addr,data,fd}", i),
            (got_q[i].addr << 9) | (got_q[i].data << 1) | int'(got_q[i].fd),
            (exp_q[i].addr << 9) | (exp_q[i].data << 1) | int'(exp_q[i].fd));
    check("random contrast", int'(bus.contrast), m_contrast);
    check("random display_on", int'(bus.display_on), m_on);
    check("random invert", int'(bus.invert), m_inv);
    check("stray frame_done pulses", stray_fd, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
